// File: rtl/text_writer.sv
// Terminal-style writer: turns a stream of code points into tram writes,
// tracking the cursor, line wrap and hardware scroll of the textmode display.
module text_writer #(
  parameter int WORD      = 32,
  parameter int ADDRW     = 12,
  parameter int CIDXW     = 4,
  parameter int TRAM_HRES = 80,
  parameter int TRAM_VRES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [20:0]        in_ucp,
  input  logic [CIDXW-1:0]   colr_fg,
  input  logic [CIDXW-1:0]   colr_bg,
  output logic               tram_we,
  output logic [ADDRW-1:0]   tram_addr,
  output logic [WORD-1:0]    tram_din,
  output logic [ADDRW-1:0]   scroll_offs,
  output logic [ADDRW-1:0]   cursor_x,
  output logic [ADDRW-1:0]   cursor_y
);

  localparam int PAD = WORD - 2*CIDXW - 21;
  localparam logic [ADDRW-1:0] ONE       = ADDRW'(1);
  localparam logic [ADDRW-1:0] HRES      = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] LAST_X    = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] LAST_Y    = ADDRW'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(TRAM_HRES*TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] LAST_LINE = ADDRW'(TRAM_HRES*TRAM_VRES - TRAM_HRES);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

  state_t             state, state_nxt;
  logic [ADDRW-1:0]   line_base, line_base_nxt;
  logic [ADDRW-1:0]   clr_cnt, clr_cnt_nxt;
  logic [CIDXW-1:0]   fg_lat, fg_lat_nxt, bg_lat, bg_lat_nxt;
  logic [ADDRW-1:0]   scroll_nxt, cx_nxt, cy_nxt, addr_nxt;
  logic [WORD-1:0]    din_nxt;
  logic               we_nxt, ready_nxt;

  logic               accept, is_lf, is_cr, is_bs, is_ff, is_ctrl;
  logic               wrap, newline, scroll, clr_last;
  logic [ADDRW-1:0]   lb_adv, so_adv;
  logic [CIDXW-1:0]   fg_clr, bg_clr;

  assign accept   = in_valid && in_ready;
  assign is_lf    = in_ucp == 21'h0A;
  assign is_cr    = in_ucp == 21'h0D;
  assign is_bs    = in_ucp == 21'h08;
  assign is_ff    = in_ucp == 21'h0C;
  assign is_ctrl  = in_ucp < 21'h20;
  assign wrap     = !is_ctrl && (cursor_x == LAST_X);
  assign newline  = is_lf || wrap;
  assign scroll   = newline && (cursor_y == LAST_Y);
  assign lb_adv   = (line_base == LAST_LINE) ? '0 : line_base + HRES;
  assign so_adv   = (scroll_offs == LAST_LINE) ? '0 : scroll_offs + HRES;
  assign clr_last = (state == CLR_LINE) ? (clr_cnt == LAST_X) : (clr_cnt == LAST_ADDR);
  // Colours are live on the first clear cycle and latched for the rest.
  assign fg_clr   = (clr_cnt == '0) ? colr_fg : fg_lat;
  assign bg_clr   = (clr_cnt == '0) ? colr_bg : bg_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLR_ALL;
      in_ready    <= 1'b0;
      tram_we     <= 1'b0;
      tram_addr   <= '0;
      tram_din    <= '0;
      scroll_offs <= '0;
      cursor_x    <= '0;
      cursor_y    <= '0;
      line_base   <= '0;
      clr_cnt     <= '0;
      fg_lat      <= '0;
      bg_lat      <= '0;
    end else begin
      state       <= state_nxt;
      in_ready    <= ready_nxt;
      tram_we     <= we_nxt;
      tram_addr   <= addr_nxt;
      tram_din    <= din_nxt;
      scroll_offs <= scroll_nxt;
      cursor_x    <= cx_nxt;
      cursor_y    <= cy_nxt;
      line_base   <= line_base_nxt;
      clr_cnt     <= clr_cnt_nxt;
      fg_lat      <= fg_lat_nxt;
      bg_lat      <= bg_lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_ff)       state_nxt = CLR_ALL;
          else if (scroll) state_nxt = CLR_LINE;
        end
      end
      CLR_LINE, CLR_ALL: if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_nxt     = (state_nxt == IDLE);
    we_nxt        = 1'b0;
    addr_nxt      = tram_addr;
    din_nxt       = tram_din;
    scroll_nxt    = scroll_offs;
    cx_nxt        = cursor_x;
    cy_nxt        = cursor_y;
    line_base_nxt = line_base;
    clr_cnt_nxt   = clr_cnt;
    fg_lat_nxt    = fg_lat;
    bg_lat_nxt    = bg_lat;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_ff) begin
            scroll_nxt    = '0;
            line_base_nxt = '0;
            cx_nxt        = '0;
            cy_nxt        = '0;
            clr_cnt_nxt   = '0;
          end else if (is_lf || is_cr) begin
            cx_nxt = '0;
          end else if (is_bs) begin
            if (cursor_x != '0) cx_nxt = cursor_x - ONE;
          end else if (!is_ctrl) begin
            we_nxt   = 1'b1;
            addr_nxt = line_base + cursor_x;
            din_nxt  = {colr_bg, colr_fg, {PAD{1'b0}}, in_ucp};
            cx_nxt   = wrap ? '0 : cursor_x + ONE;
          end
          if (newline) begin
            line_base_nxt = lb_adv;
            if (scroll) scroll_nxt = so_adv;
            else        cy_nxt     = cursor_y + ONE;
          end
        end
      end
      CLR_LINE, CLR_ALL: begin
        we_nxt      = 1'b1;
        addr_nxt    = (state == CLR_LINE) ? line_base + clr_cnt : clr_cnt;
        din_nxt     = {bg_clr, fg_clr, {PAD{1'b0}}, 21'h20};
        fg_lat_nxt  = fg_clr;
        bg_lat_nxt  = bg_clr;
        clr_cnt_nxt = clr_last ? '0 : clr_cnt + ONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_text_writer.sv
// Randomized bench for text_writer against a screen-level model of the
// terminal (cursor, scroll offset and the list of tram writes owed).
module tb_text_writer;
  localparam int WORD = 32, ADDRW = 12, CIDXW = 4, H = 4, V = 3, SIZE = H*V;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [20:0] in_ucp = '0;
  logic [CIDXW-1:0] colr_fg = '0, colr_bg = '0;
  logic tram_we;
  logic [ADDRW-1:0] tram_addr, scroll_offs, cursor_x, cursor_y;
  logic [WORD-1:0] tram_din;

  always #5 clk = ~clk;

  text_writer #(.WORD(WORD), .ADDRW(ADDRW), .CIDXW(CIDXW), .TRAM_HRES(H), .TRAM_VRES(V)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ucp(in_ucp),
    .colr_fg(colr_fg), .colr_bg(colr_bg), .tram_we(tram_we), .tram_addr(tram_addr),
    .tram_din(tram_din), .scroll_offs(scroll_offs), .cursor_x(cursor_x), .cursor_y(cursor_y));

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int checks = 0, errors = 0;
  int m_x = 0, m_y = 0, m_scroll = 0, busy = 0, pend = 0, pend_base = 0;
  bit rand_colr = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input logic [3:0] fg, input logic [3:0] bg, input logic [20:0] u);
    return (32'(bg) << 28) | (32'(fg) << 24) | 32'(u);
  endfunction

  task automatic model_newline();
    if (m_y < V-1) m_y++;
    else begin
      m_scroll  = (m_scroll + H) % SIZE;
      busy      = H;
      pend      = 1;
      pend_base = (m_scroll + m_y*H) % SIZE;
    end
  endtask

  task automatic model_accept(input logic [20:0] u);
    if (u == 21'h0A) begin m_x = 0; model_newline(); end
    else if (u == 21'h0D) m_x = 0;
    else if (u == 21'h08) begin if (m_x > 0) m_x--; end
    else if (u == 21'h0C) begin m_x = 0; m_y = 0; m_scroll = 0; busy = SIZE; pend = 2; end
    else if (u >= 21'h20) begin
      exp_q.push_back('{32'((m_scroll + m_y*H + m_x) % SIZE), mkdata(colr_fg, colr_bg, u)});
      if (m_x == H-1) begin m_x = 0; model_newline(); end
      else m_x++;
    end
  endtask

  task automatic push_clear();
    if (pend == 1)
      for (int k = 0; k < H; k++) exp_q.push_back('{32'(pend_base + k), mkdata(colr_fg, colr_bg, 21'h20)});
    else if (pend == 2)
      for (int k = 0; k < SIZE; k++) exp_q.push_back('{32'(k), mkdata(colr_fg, colr_bg, 21'h20)});
    pend = 0;
  endtask

  function automatic logic [20:0] rand_ucp();
    case ($urandom_range(0, 15))
      0: return 21'h0A;
      1: return 21'h0D;
      2: return 21'h08;
      3: return ($urandom_range(0, 5) == 0) ? 21'h0C : 21'h07;
      4: return 21'($urandom_range(0, 31));
      default: return 21'($urandom_range(32, 21'h1FFFFF));
    endcase
  endfunction

  // mode 0: idle, 1: send u when ready, 2: random traffic
  task automatic step(input int mode, input logic [20:0] u, output bit sent);
    bit rdy;
    logic [20:0] uu;
    @(negedge clk);
    rdy = (busy == 0);
    check("in_ready", in_ready, rdy);
    if (busy > 0) busy--;
    check("cursor_x", cursor_x, m_x);
    check("cursor_y", cursor_y, m_y);
    check("scroll_offs", scroll_offs, m_scroll);
    if (rand_colr) begin
      colr_fg = 4'($urandom);
      colr_bg = 4'($urandom);
    end
    push_clear();
    sent     = 1'b0;
    in_valid = 1'b0;
    in_ucp   = 21'($urandom);
    if (rdy && (mode == 1 || (mode == 2 && $urandom_range(0, 3) != 0))) begin
      uu       = (mode == 1) ? u : rand_ucp();
      in_valid = 1'b1;
      in_ucp   = uu;
      model_accept(uu);
      sent     = 1'b1;
    end
  endtask

  task automatic send(input logic [20:0] u);
    bit s;
    int n = 0;
    do begin step(1, u, s); n++; end while (!s && n < 50);
    if (!s) check("send_timeout", s, 1);
  endtask

  task automatic idle(input int n);
    bit s;
    repeat (n) step(0, '0, s);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy != 0) && n < 200) begin idle(1); n++; end
    idle(1);
    check("drain_q", exp_q.size(), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    colr_fg  = 4'($urandom);
    colr_bg  = 4'($urandom);
    in_valid = 1'b0;
    rst      = 1'b0;
    m_x = 0; m_y = 0; m_scroll = 0;
    busy = SIZE - 1;
    pend = 2;
    push_clear();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_tram_we", tram_we, 0);
    check("rst_tram_addr", tram_addr, 0);
    check("rst_tram_din", tram_din, 0);
    check("rst_scroll", scroll_offs, 0);
    check("rst_cursor_x", cursor_x, 0);
    check("rst_cursor_y", cursor_y, 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst && tram_we) begin
      if (exp_q.size() == 0) check("tram_we_extra", tram_we, 0);
      else begin
        e = exp_q.pop_front();
        check("tram_addr", tram_addr, e.addr);
        check("tram_din", tram_din, e.data);
      end
    end
  end

  initial begin
    bit s;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    release_reset();
    drain();

    // directed: fixed colours, wrap, scroll, BS/CR/BEL
    rand_colr = 1'b0;
    colr_fg = 4'd3;
    colr_bg = 4'd1;
    send(21'h41);
    send(21'h42); send(21'h43); send(21'h44); send(21'h45);
    send(21'h08); send(21'h08);
    send(21'h58); send(21'h0D); send(21'h07);
    send(21'h0A); send(21'h0A); send(21'h0A);
    send(21'h1F600);
    drain();

    rand_colr = 1'b1;
    repeat (3000) step(2, '0, s);
    drain();

    // scroll twice, form feed, then reset in the middle of the clear
    send(21'h0A); send(21'h0A); send(21'h0A); send(21'h0A);
    drain();
    send(21'h0C);
    idle(5);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    exp_q.delete();
    pend = 0;
    busy = 0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    drain();
    repeat (500) step(2, '0, s);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Terminal-style writer that turns a stream of Unicode code points into tram writes for the textmode display.
- Maintains the cursor, line wrap, CR/LF/BS/FF handling and hardware scrolling. Scrolling is done by advancing scroll_offs and clearing the recycled line.
- Sits between the CPU/console FIFO and the tram write port.
- Its scroll_offs output drives the textmode renderer's scroll offset.

Parameters:
- WORD, 32, machine word / tram data width (bits)
- ADDRW, 12, tram address width (bits); must hold TRAM_HRES*TRAM_VRES-1
- CIDXW, 4, colour index width (bits)
- TRAM_HRES, 80, tram width (chars)
- TRAM_VRES, 30, tram height (chars)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  code point available
- in_ready  out  1  writer can accept a code point this cycle
- in_ucp  in  21  Unicode code point
- colr_fg  in  CIDXW  foreground colour for writes/clears
- colr_bg  in  CIDXW  background colour for writes/clears
- tram_we  out  1  tram write enable
- tram_addr  out  ADDRW  tram write address
- tram_din  out  WORD  tram write data
- scroll_offs  out  ADDRW  tram address of top-left displayed char
- cursor_x  out  ADDRW  cursor column, 0..TRAM_HRES-1
- cursor_y  out  ADDRW  cursor row, 0..TRAM_VRES-1

Behaviour:
- Definitions:
  - SIZE = TRAM_HRES*TRAM_VRES.
  - All address arithmetic is modulo SIZE.
  - line_base is an internal register holding the tram address of the cursor row, always a multiple of TRAM_HRES.
  - Write address = line_base + cursor_x. No wrap is needed within a line.
- tram_din format:
  - bg in [WORD-1:WORD-CIDXW], fg in [WORD-CIDXW-1:WORD-2*CIDXW], ucp in [20:0].
  - All other bits are 0.
  - Colours are sampled in the accept cycle (printable char) or the first cycle of a clear.
- Reset (async):
  - state=CLR_ALL, in_ready=0, tram_we=0, tram_addr=0, tram_din=0.
  - scroll_offs=0, cursor_x=0, cursor_y=0, line_base=0, clear counter=0.
- States and handshake:
  - IDLE: in_ready=1. Accept occurs when in_valid && in_ready. Outputs are registered: any tram write appears the cycle after acceptance.
  - CLR_LINE: in_ready=0. Writes a space (0x20) to line_base+k for k=0..TRAM_HRES-1, one per cycle (TRAM_HRES consecutive tram_we cycles), then returns to IDLE.
  - CLR_ALL: in_ready=0. Writes a space to addresses 0..SIZE-1, one per cycle, then returns to IDLE.
- Accepted code points:
  - 0x0A LF: cursor_x=0, then newline.
  - 0x0D CR: cursor_x=0. No write.
  - 0x08 BS: if cursor_x>0, cursor_x-1. No write, no erase. At column 0, no change.
  - 0x0C FF: scroll_offs=0, line_base=0, cursor=(0,0), go to CLR_ALL.
  - Other codes below 0x20: ignored, consumed.
  - Printable: one write at line_base+cursor_x. Then cursor_x+1. If cursor_x was TRAM_HRES-1, instead cursor_x=0 and newline. Sustained throughput is 1 char/cycle except when a scroll occurs.
- Newline:
  - cursor_y < TRAM_VRES-1: cursor_y+1, line_base+=TRAM_HRES, stay IDLE.
  - cursor_y == TRAM_VRES-1 (scroll): cursor_y unchanged, scroll_offs+=TRAM_HRES, line_base+=TRAM_HRES (both mod SIZE), go to CLR_LINE.
  - scroll_offs and line_base update in the same cycle tram_we of the last char (if any) is asserted.
- tram_we is high only for the writes above, never in other cycles.
- Reset mid-clear: abort immediately; the whole clear restarts via CLR_ALL.
- Colour inputs changing mid-clear: ignored; the clear uses the colours latched at its first cycle.

Test Plan:
(Config HRES=4, VRES=3, SIZE=12, WORD=32, CIDXW=4.)
1. Release reset -> in_ready=0 for 12 cycles. tram_we writes addr 0..11 with data {bg,fg,0x20}. Then in_ready=1, cursor=(0,0).
2. Send 'A' (0x41), fg=3, bg=1, in IDLE -> next cycle tram_we=1, addr 0, tram_din=0x13000041. cursor_x=1.
3. Send 4 printables back-to-back -> addrs 0,1,2,3 on consecutive cycles, in_ready stays 1. Cursor ends at (0,1), line_base=4.
4. Cursor at (2,2) with scroll_offs=0, send LF -> scroll_offs=4, line_base=0, cursor=(0,2). in_ready=0 for 4 cycles while spaces are written to addrs 0..3.
5. Cursor at (0,1): send BS -> cursor unchanged, no write. Send CR after 'X' -> cursor_x=0. Send 0x07 -> no change, consumed.
6. After two scrolls (scroll_offs=8), send FF -> scroll_offs=0, cursor=(0,0), 12 clear writes. Assert rst at clear cycle 5 -> all outputs at reset values immediately, then a full 12-write clear follows.
